// File: rtl/alu_issue.sv
// MIPS execute-issue stage: decodes an instruction into ALU control/operands/shamt and
// queues it in a 2-entry skid buffer. Define ALU_ISSUE_FWD_EN to enable EX/MEM forwarding.
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        fwd_valid,
    input  logic [4:0]  fwd_reg,
    input  logic [31:0] fwd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_control,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic [4:0]  shamt,
    output logic [4:0]  dest_reg,
    output logic        write_en,
    output logic        illegal
);

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  shamt;
        logic [4:0]  dest;
        logic        we;
        logic        ill;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    entry_t r_head;
    entry_t r_skid;
    entry_t w_dec;

    logic        w_load_head;
    logic        w_load_skid;
    logic        w_head_from_skid;
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_imm;
    logic [3:0]  w_code;
    logic        w_legal;
    logic        w_is_i;
    logic        w_sext;

    assign w_opcode = instr[31:26];
    assign w_funct  = instr[5:0];
    assign w_rs     = instr[25:21];
    assign w_rt     = instr[20:16];

`ifdef ALU_ISSUE_FWD_EN
    // $0 is hardwired, so a forwarded write to it must never be substituted.
    assign w_rs_val = (fwd_valid && (fwd_reg == w_rs) && (w_rs != 5'd0)) ? fwd_data : rs_data;
    assign w_rt_val = (fwd_valid && (fwd_reg == w_rt) && (w_rt != 5'd0)) ? fwd_data : rt_data;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_valid, fwd_reg, fwd_data};
    assign w_rs_val = rs_data;
    assign w_rt_val = rt_data;
`endif

    always_comb begin
        w_legal = 1'b1;
        w_code  = 4'd0;
        w_is_i  = 1'b0;
        w_sext  = 1'b0;
        if (w_opcode == 6'h00) begin
            case (w_funct)
                6'h24:        w_code = 4'd0;
                6'h25:        w_code = 4'd1;
                6'h20, 6'h21: w_code = 4'd2;
                6'h22, 6'h23: w_code = 4'd6;
                6'h2A:        w_code = 4'd7;
                6'h2B:        w_code = 4'd8;
                6'h00:        w_code = 4'd9;
                6'h02:        w_code = 4'd10;
                6'h27:        w_code = 4'd12;
                default:      w_legal = 1'b0;
            endcase
        end else begin
            w_is_i = 1'b1;
            case (w_opcode)
                6'h08, 6'h09: begin w_code = 4'd2; w_sext = 1'b1; end
                6'h0A:        begin w_code = 4'd7; w_sext = 1'b1; end
                6'h0C:        w_code = 4'd0;
                6'h0D:        w_code = 4'd1;
                default:      w_legal = 1'b0;
            endcase
        end
    end

    assign w_imm = w_sext ? {{16{instr[15]}}, instr[15:0]} : {16'h0000, instr[15:0]};

    always_comb begin
        w_dec = '0;
        if (w_legal) begin
            w_dec.ctrl = w_code;
            if (w_is_i) begin
                w_dec.op1  = w_rs_val;
                w_dec.op2  = w_imm;
                w_dec.dest = instr[20:16];
            end else begin
                w_dec.dest  = instr[15:11];
                w_dec.shamt = instr[10:6];
                // The ALU subtracts input1 from input2, so swap to get rs - rt.
                if (w_code == 4'd6) begin
                    w_dec.op1 = w_rt_val;
                    w_dec.op2 = w_rs_val;
                end else begin
                    w_dec.op1 = w_rs_val;
                    w_dec.op2 = w_rt_val;
                end
            end
            w_dec.we = (w_dec.dest != 5'd0);
        end else begin
            w_dec.ill = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_EMPTY;
        else        r_state <= w_next;
    end

    // in_ready is a decode of the state register only, never of out_ready.
    always_comb begin
        w_next           = r_state;
        w_load_head      = 1'b0;
        w_load_skid      = 1'b0;
        w_head_from_skid = 1'b0;
        if (flush) begin
            w_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (in_valid) begin
                        w_load_head = 1'b1;
                        w_next      = S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_valid && out_ready) begin
                        w_load_head = 1'b1;
                    end else if (out_ready) begin
                        w_next = S_EMPTY;
                    end else if (in_valid) begin
                        w_load_skid = 1'b1;
                        w_next      = S_FULL;
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        w_head_from_skid = 1'b1;
                        w_next           = S_ONE;
                    end
                end
                default: w_next = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head)           r_head <= w_dec;
            else if (w_head_from_skid) r_head <= r_skid;
            if (w_load_skid)           r_skid <= w_dec;
        end
    end

    assign in_ready    = (r_state != S_FULL);
    assign out_valid   = (r_state != S_EMPTY);
    assign alu_control = r_head.ctrl;
    assign operand1    = r_head.op1;
    assign operand2    = r_head.op2;
    assign shamt       = r_head.shamt;
    assign dest_reg    = r_head.dest;
    assign write_en    = r_head.we;
    assign illegal     = r_head.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode, forwarding, backpressure, flush and async reset.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_control;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [4:0]  shamt;
    logic [4:0]  dest_reg;
    logic        write_en;
    logic        illegal;

    int total = 0;
    int bad   = 0;

`ifdef ALU_ISSUE_FWD_EN
    localparam logic [31:0] FWD_OP1 = 32'h0000_00AA;
`else
    localparam logic [31:0] FWD_OP1 = 32'h0000_0005;
`endif

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rs_data(rs_data), .rt_data(rt_data),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .operand1(operand1), .operand2(operand2),
        .shamt(shamt), .dest_reg(dest_reg), .write_en(write_en), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt);
        in_valid = 1'b1;
        instr    = w;
        rs_data  = rs;
        rt_data  = rt;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0;
        rs_data = '0; rt_data = '0; fwd_valid = 1'b0; fwd_reg = '0; fwd_data = '0;
        out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_ctrl", {28'd0, alu_control}, 32'd0);
        chk("rst_op1", operand1, 32'd0);
        chk("rst_op2", operand2, 32'd0);
        chk("rst_we_ill", {30'd0, write_en, illegal}, 32'd0);
        rst_n = 1'b1;

        // add $3,$1,$2
        offer(32'h0022_1820, 32'd5, 32'd7); tick();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_ctrl", {28'd0, alu_control}, 32'd2);
        chk("add_op1", operand1, 32'd5);
        chk("add_op2", operand2, 32'd7);
        chk("add_dest", {27'd0, dest_reg}, 32'd3);
        chk("add_we_ill", {30'd0, write_en, illegal}, 32'd2);

        // sub $4,$1,$2 replaces the head while it drains
        offer(32'h0022_2022, 32'd9, 32'd2); tick();
        chk("sub_ctrl", {28'd0, alu_control}, 32'd6);
        chk("sub_op1", operand1, 32'd2);
        chk("sub_op2", operand2, 32'd9);
        chk("sub_dest", {27'd0, dest_reg}, 32'd4);
        chk("sub_in_ready", {31'd0, in_ready}, 32'd1);

        // addi $5,$1,-1
        offer(32'h2025_FFFF, 32'd3, 32'd99); tick();
        chk("addi_ctrl", {28'd0, alu_control}, 32'd2);
        chk("addi_op1", operand1, 32'd3);
        chk("addi_op2", operand2, 32'hFFFF_FFFF);
        chk("addi_dest", {27'd0, dest_reg}, 32'd5);

        // ori $6,$1,0xFFFF
        offer(32'h3426_FFFF, 32'd3, 32'd99); tick();
        chk("ori_ctrl", {28'd0, alu_control}, 32'd1);
        chk("ori_op2", operand2, 32'h0000_FFFF);
        chk("ori_shamt", {27'd0, shamt}, 32'd0);

        // sll $7,$2,4
        offer(32'h0002_3900, 32'h11, 32'h22); tick();
        chk("sll_ctrl", {28'd0, alu_control}, 32'd9);
        chk("sll_op1", operand1, 32'h11);
        chk("sll_op2", operand2, 32'h22);
        chk("sll_shamt", {27'd0, shamt}, 32'd4);
        chk("sll_dest", {27'd0, dest_reg}, 32'd7);

        // sltu and nor
        offer(32'h0022_402B, 32'd1, 32'd2); tick();
        chk("sltu_ctrl", {28'd0, alu_control}, 32'd8);
        offer(32'h0022_4027, 32'd1, 32'd2); tick();
        chk("nor_ctrl", {28'd0, alu_control}, 32'd12);

        // forwarding on rs=$1, then on $0 (never substituted)
        fwd_valid = 1'b1; fwd_reg = 5'd1; fwd_data = 32'hAA;
        offer(32'h0022_1820, 32'd5, 32'd7); tick();
        chk("fwd_op1", operand1, FWD_OP1);
        chk("fwd_op2", operand2, 32'd7);
        fwd_reg = 5'd0;
        offer(32'h0002_1820, 32'd5, 32'd7); tick();
        chk("fwd_zero_op1", operand1, 32'd5);
        fwd_valid = 1'b0;

        // NOP and illegal opcode 0x3F
        offer(32'h0000_0000, 32'd1, 32'd1); tick();
        chk("nop_valid", {31'd0, out_valid}, 32'd1);
        chk("nop_we_ill", {30'd0, write_en, illegal}, 32'd0);
        offer(32'hFC22_1820, 32'd5, 32'd7); tick();
        chk("ill_valid", {31'd0, out_valid}, 32'd1);
        chk("ill_we_ill", {30'd0, write_en, illegal}, 32'd1);
        chk("ill_ctrl", {28'd0, alu_control}, 32'd0);
        chk("ill_op1", operand1, 32'd0);
        chk("ill_op2", operand2, 32'd0);
        in_valid = 1'b0; tick();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // backpressure: A, B accepted, C refused until space frees
        out_ready = 1'b0;
        offer(32'h0022_1820, 32'h101, 32'h102); tick();
        chk("bp_a_ready", {31'd0, in_ready}, 32'd1);
        offer(32'h0022_2022, 32'h201, 32'h202); tick();
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_op1", operand1, 32'h101);
        offer(32'h0022_4825, 32'h301, 32'h302); tick(); tick();
        chk("bp_still_full", {31'd0, in_ready}, 32'd0);
        chk("bp_frozen_op1", operand1, 32'h101);
        chk("bp_frozen_ctrl", {28'd0, alu_control}, 32'd2);
        out_ready = 1'b1; tick();
        chk("bp_b_ctrl", {28'd0, alu_control}, 32'd6);
        chk("bp_b_op1", operand1, 32'h202);
        chk("bp_b_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_c_ctrl", {28'd0, alu_control}, 32'd1);
        chk("bp_c_op1", operand1, 32'h301);
        in_valid = 1'b0; tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // flush with both entries full and an input offered
        out_ready = 1'b0;
        offer(32'h0022_1820, 32'd1, 32'd2); tick();
        offer(32'h0022_2022, 32'd3, 32'd4); tick();
        chk("fl_full", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        offer(32'h0022_4825, 32'd5, 32'd6); tick();
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_ready", {31'd0, in_ready}, 32'd1);
        flush = 1'b0; in_valid = 1'b0; tick();
        chk("fl_discard", {31'd0, out_valid}, 32'd0);

        // asynchronous reset between edges
        offer(32'h0022_1820, 32'd1, 32'd2); tick();
        in_valid = 1'b0; tick();
        chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_op1", operand1, 32'd0);
        chk("ar_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
